// File: rtl/des_key_sched_ctrl.sv
// Iterative DES round-key scheduler.
// One shift/PC-2 datapath is stepped once per accepted round key. Keys go out
// over a valid/ready handshake in encrypt order (K1..K16) or decrypt order
// (K16..K1).
module des_key_sched_ctrl #(
   parameter int unsigned DECRYPT_EN = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic        decrypt,
   input  logic [63:0] key,
   output logic        busy,
   output logic        rk_valid,
   input  logic        rk_ready,
   output logic [47:0] rk,
   output logic [3:0]  rk_round,
   output logic        rk_last,
   output logic        done
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ROUND = 2'd1,
      DONE  = 2'd2
   } state_t;

   localparam logic DEC_OK = (DECRYPT_EN != 0);

   state_t      state_q;
   logic [27:0] c_q;
   logic [27:0] d_q;
   logic [3:0]  cnt_q;
   logic        mode_q;

   logic [55:0] pc1_key;
   logic        enc_one;
   logic        dec_one;
   logic [27:0] c_enc;
   logic [27:0] d_enc;
   logic [27:0] c_dec;
   logic [27:0] d_dec;
   logic [27:0] c_nxt;
   logic [27:0] d_nxt;
   logic [55:0] cd_sel;
   logic [47:0] pc2_out;
   logic        handshake;
   logic        key_parity_unused;
   logic        cd_drop_unused;

   // PC-1: key bit n (FIPS numbering, 1 = MSB) is key[64-n]; parity bits are dropped.
   assign pc1_key = {
      key[7],  key[15], key[23], key[31], key[39], key[47], key[55],
      key[63], key[6],  key[14], key[22], key[30], key[38], key[46],
      key[54], key[62], key[5],  key[13], key[21], key[29], key[37],
      key[45], key[53], key[61], key[4],  key[12], key[20], key[28],
      key[1],  key[9],  key[17], key[25], key[33], key[41], key[49],
      key[57], key[2],  key[10], key[18], key[26], key[34], key[42],
      key[50], key[58], key[3],  key[11], key[19], key[27], key[35],
      key[43], key[51], key[59], key[36], key[44], key[52], key[60]
   };

   assign key_parity_unused = ^{key[56], key[48], key[40], key[32],
                                key[24], key[16], key[8],  key[0]};

   // Single-bit shift rounds: k in {1,2,9,16}. Encrypt uses k = cnt+1, decrypt k = 16-cnt.
   assign enc_one = (cnt_q == 4'd0) || (cnt_q == 4'd1) || (cnt_q == 4'd8)  || (cnt_q == 4'd15);
   assign dec_one = (cnt_q == 4'd0) || (cnt_q == 4'd7) || (cnt_q == 4'd14) || (cnt_q == 4'd15);

   assign c_enc = enc_one ? {c_q[26:0], c_q[27]} : {c_q[25:0], c_q[27:26]};
   assign d_enc = enc_one ? {d_q[26:0], d_q[27]} : {d_q[25:0], d_q[27:26]};
   assign c_dec = dec_one ? {c_q[0], c_q[27:1]}  : {c_q[1:0], c_q[27:2]};
   assign d_dec = dec_one ? {d_q[0], d_q[27:1]}  : {d_q[1:0], d_q[27:2]};

   // Encrypt presents the pre-rotated halves so the registers always hold C(k-1)/D(k-1);
   // decrypt starts from C16/D16 (== C0/D0) and presents the registers directly.
   assign c_nxt  = mode_q ? c_dec : c_enc;
   assign d_nxt  = mode_q ? d_dec : d_enc;
   assign cd_sel = mode_q ? {c_q, d_q} : {c_enc, d_enc};

   // PC-2: CD bit n (1 = MSB) is cd_sel[56-n].
   assign pc2_out = {
      cd_sel[42], cd_sel[39], cd_sel[45], cd_sel[32], cd_sel[55], cd_sel[51],
      cd_sel[53], cd_sel[28], cd_sel[41], cd_sel[50], cd_sel[35], cd_sel[46],
      cd_sel[33], cd_sel[37], cd_sel[44], cd_sel[52], cd_sel[30], cd_sel[48],
      cd_sel[40], cd_sel[49], cd_sel[29], cd_sel[36], cd_sel[43], cd_sel[54],
      cd_sel[15], cd_sel[4],  cd_sel[25], cd_sel[19], cd_sel[9],  cd_sel[1],
      cd_sel[26], cd_sel[16], cd_sel[5],  cd_sel[11], cd_sel[23], cd_sel[8],
      cd_sel[12], cd_sel[7],  cd_sel[17], cd_sel[0],  cd_sel[22], cd_sel[3],
      cd_sel[10], cd_sel[14], cd_sel[6],  cd_sel[20], cd_sel[27], cd_sel[24]
   };

   assign cd_drop_unused = ^{cd_sel[47], cd_sel[38], cd_sel[34], cd_sel[31],
                             cd_sel[21], cd_sel[18], cd_sel[13], cd_sel[2]};

   assign handshake = rk_valid & rk_ready;

   // Presented key fields are forced to zero whenever no key is valid.
   always_comb begin
      rk       = '0;
      rk_round = '0;
      rk_last  = 1'b0;
      if (rk_valid) begin
         rk       = pc2_out;
         rk_round = cnt_q;
         rk_last  = (cnt_q == 4'd15);
      end
   end

   // Controller: latch key/order on start, step C/D per handshake, pulse done once.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         c_q      <= '0;
         d_q      <= '0;
         cnt_q    <= '0;
         mode_q   <= 1'b0;
         busy     <= 1'b0;
         rk_valid <= 1'b0;
         done     <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state_q)
            IDLE: begin
               if (start) begin
                  {c_q, d_q} <= pc1_key;
                  cnt_q      <= '0;
                  mode_q     <= decrypt & DEC_OK;
                  busy       <= 1'b1;
                  rk_valid   <= 1'b1;
                  state_q    <= ROUND;
               end
            end
            ROUND: begin
               if (handshake) begin
                  c_q <= c_nxt;
                  d_q <= d_nxt;
                  // cnt parks at 15 so it never wraps; the 16th handshake leaves ROUND.
                  if (cnt_q == 4'd15) begin
                     busy     <= 1'b0;
                     rk_valid <= 1'b0;
                     done     <= 1'b1;
                     state_q  <= DONE;
                  end else begin
                     cnt_q <= cnt_q + 4'd1;
                  end
               end
            end
            DONE: begin
               state_q <= IDLE;
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_des_key_sched_ctrl.sv
// Directed bench for des_key_sched_ctrl using the classic 133457799BBCDFF1 key schedule.
module tb_des_key_sched_ctrl;

   logic        clk;
   logic        rst;
   logic        start;
   logic        decrypt;
   logic [63:0] key;
   logic        rk_ready;

   logic        busy;
   logic        rk_valid;
   logic [47:0] rk;
   logic [3:0]  rk_round;
   logic        rk_last;
   logic        done;

   logic        e_busy;
   logic        e_rk_valid;
   logic [47:0] e_rk;
   logic [3:0]  e_rk_round;
   logic        e_rk_last;
   logic        e_done;

   int unsigned n_checks = 0;
   int unsigned n_fail   = 0;

   localparam logic [63:0] TKEY = 64'h133457799BBCDFF1;
   // PC1(TKEY): C0 = F0CCAAF, D0 = 556678F
   localparam logic [55:0] CD0  = 56'hF0CCAAF556678F;
   localparam int unsigned NONE = 99;

   logic [47:0] ks [16] = '{
      48'h1B02EFFC7072, 48'h79AED9DBC9E5, 48'h55FC8A42CF99, 48'h72ADD6DB351D,
      48'h7CEC07EB53A8, 48'h63A53E507B2F, 48'hEC84B7F618BC, 48'hF78A3AC13BFB,
      48'hE0DBEBEDE781, 48'hB1F347BA464F, 48'h215FD3DED386, 48'h7571F59467E9,
      48'h97C5D1FABA41, 48'h5F43B7F2E73A, 48'hBF918D3D3F0A, 48'hCB3D8B0E17F5
   };

   des_key_sched_ctrl dut (
      .clk      (clk),
      .rst      (rst),
      .start    (start),
      .decrypt  (decrypt),
      .key      (key),
      .busy     (busy),
      .rk_valid (rk_valid),
      .rk_ready (rk_ready),
      .rk       (rk),
      .rk_round (rk_round),
      .rk_last  (rk_last),
      .done     (done)
   );

   des_key_sched_ctrl #(.DECRYPT_EN(0)) u_enc (
      .clk      (clk),
      .rst      (rst),
      .start    (start),
      .decrypt  (decrypt),
      .key      (key),
      .busy     (e_busy),
      .rk_valid (e_rk_valid),
      .rk_ready (rk_ready),
      .rk       (e_rk),
      .rk_round (e_rk_round),
      .rk_last  (e_rk_last),
      .done     (e_done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic check_quiet(input string tag);
      check({tag, "_busy"},  64'(busy),     64'd0);
      check({tag, "_valid"}, 64'(rk_valid), 64'd0);
      check({tag, "_rk"},    64'(rk),       64'd0);
      check({tag, "_round"}, 64'(rk_round), 64'd0);
      check({tag, "_last"},  64'(rk_last),  64'd0);
      check({tag, "_done"},  64'(done),     64'd0);
      check({tag, "_evalid"}, 64'(e_rk_valid), 64'd0);
   endtask

   // Runs one schedule from the start pulse through the IDLE cycle after done.
   task automatic run_sched(input logic [63:0] k, input logic dec, input int unsigned pct,
                            input bit zero_key, input bit hold,
                            input int unsigned start_at, input int unsigned rst_at);
      int unsigned n;
      int unsigned cyc;
      logic        stalled;
      logic [47:0] h_rk;
      logic [3:0]  h_rnd;
      logic        h_last;
      logic [47:0] exp_rk;
      logic [47:0] exp_e;
      logic [55:0] exp_cd;
      n = 0; cyc = 0; stalled = 1'b0; h_rk = '0; h_rnd = '0; h_last = 1'b0;
      exp_cd  = zero_key ? '0 : CD0;
      key     = k;
      decrypt = dec;
      start   = 1'b1;
      @(posedge clk); #1;
      while (n < 16 && cyc < 400) begin
         start = hold || (n == start_at);
         if (n == start_at) begin
            key     = 64'h0;
            decrypt = ~dec;
         end
         check("busy_round", 64'(busy), 64'd1);
         check("valid_round", 64'(rk_valid), 64'd1);
         if (stalled) begin
            check("hold_rk",    64'(rk),       64'(h_rk));
            check("hold_round", 64'(rk_round), 64'(h_rnd));
            check("hold_last",  64'(rk_last),  64'(h_last));
         end
         if (n == rst_at) begin
            check("pre_rst_round", 64'(rk_round), 64'(rst_at));
            rst = 1'b1;
            @(posedge clk); #1;
            rst   = 1'b0;
            start = 1'b0;
            check_quiet("mid_rst");
            check("mid_rst_state", 64'(dut.state_q), 64'd0);
            check("mid_rst_cnt",   64'(dut.cnt_q),   64'd0);
            check("mid_rst_cd",    64'({dut.c_q, dut.d_q}), 64'd0);
            return;
         end
         rk_ready = ($urandom_range(99) < pct);
         if (rk_ready) begin
            exp_rk = zero_key ? 48'h0 : (dec ? ks[15-n] : ks[n]);
            exp_e  = zero_key ? 48'h0 : ks[n];
            check("rk",       64'(rk),       64'(exp_rk));
            check("rk_round", 64'(rk_round), 64'(n));
            check("rk_last",  64'(rk_last),  64'(n == 15));
            check("enc_only_rk", 64'(e_rk),  64'(exp_e));
            n++;
         end
         stalled = !rk_ready;
         h_rk    = rk;
         h_rnd   = rk_round;
         h_last  = rk_last;
         @(posedge clk); #1;
         cyc++;
      end
      check("handshakes", 64'(n), 64'd16);
      start    = hold;
      rk_ready = 1'b1;
      check("done_pulse",  64'(done),     64'd1);
      check("done_busy",   64'(busy),     64'd0);
      check("done_valid",  64'(rk_valid), 64'd0);
      check("done_rk",     64'(rk),       64'd0);
      check("done_last",   64'(rk_last),  64'd0);
      check("enc_done",    64'(e_done),   64'd1);
      check("cd_restored", 64'({dut.c_q, dut.d_q}),     64'(exp_cd));
      check("e_cd_restored", 64'({u_enc.c_q, u_enc.d_q}), 64'(exp_cd));
      @(posedge clk); #1;
      check("done_once",  64'(done),     64'd0);
      check("idle_valid", 64'(rk_valid), 64'd0);
      check("idle_busy",  64'(busy),     64'd0);
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; decrypt = 1'b0; key = '0; rk_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check_quiet("in_rst");
      rst = 1'b0;
      @(posedge clk); #1;
      check_quiet("post_rst");

      // Ready while idle must not start anything.
      rk_ready = 1'b1;
      repeat (3) begin
         @(posedge clk); #1;
         check_quiet("idle_ready");
      end

      run_sched(TKEY, 1'b0, 100, 1'b0, 1'b0, NONE, NONE);
      run_sched(TKEY, 1'b1, 100, 1'b0, 1'b0, NONE, NONE);
      run_sched(TKEY, 1'b0, 30,  1'b0, 1'b0, NONE, NONE);
      run_sched(TKEY, 1'b1, 30,  1'b0, 1'b0, NONE, NONE);

      // Ignored start at round 5, reset at round 7, then a fresh schedule.
      run_sched(TKEY, 1'b0, 100, 1'b0, 1'b0, 5, 7);
      @(posedge clk); #1;
      check_quiet("after_rst_idle");
      run_sched(TKEY, 1'b0, 100, 1'b0, 1'b0, NONE, NONE);

      run_sched(64'h0000000000000000, 1'b0, 100, 1'b1, 1'b0, NONE, NONE);
      run_sched(64'h0101010101010101, 1'b1, 100, 1'b1, 1'b0, NONE, NONE);

      // Start held high: each schedule follows one IDLE cycle after DONE.
      run_sched(TKEY, 1'b0, 100, 1'b0, 1'b1, NONE, NONE);
      run_sched(TKEY, 1'b1, 100, 1'b0, 1'b1, NONE, NONE);
      run_sched(TKEY, 1'b0, 50,  1'b0, 1'b1, NONE, NONE);
      start = 1'b0;
      @(posedge clk); #1;
      check_quiet("final_idle");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
